// File: rtl/key_loader_if.sv
// Handshake and key-delivery bundle between a key source and key_loader.
// master drives the serial key stream and controls; slave (key_loader) returns status and the committed key.
interface key_loader_if #(
  parameter int KEY_W = 16
) ();
  logic             load_start;
  logic             key_bit;
  logic             key_valid;
  logic             load_abort;
  logic             key_ready;
  logic [KEY_W-1:0] key_out;
  logic             key_loaded;
  logic             load_err;
  logic             busy;

  modport master (
    output load_start, key_bit, key_valid, load_abort,
    input  key_ready, key_out, key_loaded, load_err, busy
  );

  modport slave (
    input  load_start, key_bit, key_valid, load_abort,
    output key_ready, key_out, key_loaded, load_err, busy
  );
endinterface

// File: rtl/key_loader.sv
// Serial key loader: shifts key bits LSB-first into a shadow register and commits them atomically to key_out.
// Define KEY_PARITY_CHECK_EN to expect a trailing even-parity bit and reject loads that fail it.
module key_loader #(
  parameter int KEY_W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  key_loader_if.slave  bus
);

`ifdef KEY_PARITY_CHECK_EN
  localparam int N = KEY_W + 1;
`else
  localparam int N = KEY_W;
`endif
  localparam int CNT_W = $clog2(KEY_W + 2);

  typedef enum logic [2:0] {IDLE, SHIFT, CHECK, LOCKED, ERROR} state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] count, count_nxt;
  logic [N-1:0]     shadow, shadow_nxt;
  logic [KEY_W-1:0] key_out_q, key_out_nxt;
  logic             key_loaded_q, key_loaded_nxt;
  logic             load_err_q, load_err_nxt;
  logic             check_pass;

`ifdef KEY_PARITY_CHECK_EN
  // Even parity: the XOR over key bits plus parity bit must be zero.
  function automatic logic parity_ok(input logic [N-1:0] v);
    return ~(^v);
  endfunction

  assign check_pass   = parity_ok(shadow);
  assign bus.load_err = load_err_q;
`else
  assign check_pass   = 1'b1;
  assign bus.load_err = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      count        <= '0;
      shadow       <= '0;
      key_out_q    <= '0;
      key_loaded_q <= 1'b0;
      load_err_q   <= 1'b0;
    end else begin
      state        <= state_nxt;
      count        <= count_nxt;
      shadow       <= shadow_nxt;
      key_out_q    <= key_out_nxt;
      key_loaded_q <= key_loaded_nxt;
      load_err_q   <= load_err_nxt;
    end
  end

  always_comb begin
    state_nxt      = state;
    count_nxt      = count;
    shadow_nxt     = shadow;
    key_out_nxt    = key_out_q;
    key_loaded_nxt = key_loaded_q;
    load_err_nxt   = load_err_q;
    unique case (state)
      IDLE, LOCKED, ERROR: begin
        if (bus.load_start) begin
          state_nxt    = SHIFT;
          count_nxt    = '0;
          shadow_nxt   = '0;
          load_err_nxt = 1'b0;
        end
      end
      SHIFT: begin
        // Abort beats restart, restart beats data.
        if (bus.load_abort) begin
          state_nxt  = key_loaded_q ? LOCKED : IDLE;
          count_nxt  = '0;
          shadow_nxt = '0;
        end else if (bus.load_start) begin
          count_nxt  = '0;
          shadow_nxt = '0;
        end else if (bus.key_valid) begin
          for (int i = 0; i < N; i++) begin
            if (count == CNT_W'(i)) shadow_nxt[i] = bus.key_bit;
          end
          count_nxt = count + 1'b1;
          if (count == CNT_W'(N - 1)) state_nxt = CHECK;
        end
      end
      CHECK: begin
        if (check_pass) begin
          state_nxt      = LOCKED;
          key_out_nxt    = shadow[KEY_W-1:0];
          key_loaded_nxt = 1'b1;
        end else begin
          state_nxt    = ERROR;
          load_err_nxt = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign bus.key_ready  = (state == SHIFT);
  assign bus.busy       = (state == SHIFT) || (state == CHECK);
  assign bus.key_out    = key_out_q;
  assign bus.key_loaded = key_loaded_q;

endmodule

// File: tb/tb_key_loader.sv
// Scoreboard bench for key_loader: stimulus queues the expected end-of-load result, a negedge monitor checks it.
module tb_key_loader;
  localparam int KEY_W = 16;
`ifdef KEY_PARITY_CHECK_EN
  localparam int N = KEY_W + 1;
`else
  localparam int N = KEY_W;
`endif

  typedef struct {
    logic [15:0] key;
    logic        loaded;
    logic        err;
    int          cyc;
  } exp_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   cyc    = 0;
  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];
  exp_t mon_e;
  exp_t ab_e;
  logic [15:0] exp_key    = '0;
  logic        exp_loaded = 1'b0;
  logic        prev_busy  = 1'b0;

  key_loader_if #(.KEY_W(KEY_W)) bus ();
  key_loader #(.KEY_W(KEY_W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got=%0h want=%0h t=%0t", name, got, want, $time);
    end
  endtask

  function automatic exp_t mk(input logic [15:0] k, input logic l, input logic er);
    exp_t e;
    e.key = k; e.loaded = l; e.err = er; e.cyc = 0;
    return e;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.load_start = 1'b0;
    bus.key_valid  = 1'b0;
    bus.key_bit    = 1'b0;
    bus.load_abort = 1'b0;
  endtask

  // key_valid rides along with load_start so a restart would expose a priority bug.
  task automatic start();
    bus.load_start = 1'b1;
    bus.key_valid  = 1'b1;
    bus.key_bit    = 1'b1;
    tick();
    idle_inputs();
  endtask

  task automatic shift_bits(input logic [15:0] key, input logic par, input int nbits,
                            input bit toggle, input bit push, input exp_t e);
    for (int i = 0; i < nbits; i++) begin
      bus.key_bit   = (i < KEY_W) ? key[i] : par;
      bus.key_valid = 1'b1;
      tick();
      if (push && i == nbits - 1) begin
        e.cyc = cyc + 1;
        sb.push_back(e);
      end
      bus.key_valid = 1'b0;
      bus.key_bit   = 1'b0;
      if (toggle) tick();
    end
  endtask

  task automatic load_key(input logic [15:0] key, input logic par, input bit toggle, input exp_t e);
    start();
    shift_bits(key, par, N, toggle, 1'b1, e);
    repeat (3) tick();
  endtask

  task automatic abort_after_11(input exp_t e);
    start();
    shift_bits(16'h0000, 1'b0, 11, 1'b0, 1'b0, e);
    bus.load_abort = 1'b1;
    bus.load_start = 1'b1;
    bus.key_valid  = 1'b1;
    bus.key_bit    = 1'b1;
    e.cyc = cyc + 1;
    sb.push_back(e);
    tick();
    idle_inputs();
    repeat (3) tick();
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        exp_key    = '0;
        exp_loaded = 1'b0;
        prev_busy  = 1'b0;
        chk("rst_key_out",    bus.key_out,    0);
        chk("rst_key_loaded", bus.key_loaded, 0);
        chk("rst_load_err",   bus.load_err,   0);
        chk("rst_busy",       bus.busy,       0);
        chk("rst_key_ready",  bus.key_ready,  0);
      end else begin
        if (prev_busy && !bus.busy) begin
          if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_done got=busy_fall want=none t=%0t", $time);
          end else begin
            mon_e = sb.pop_front();
            chk("done_key_out",    bus.key_out,    mon_e.key);
            chk("done_key_loaded", bus.key_loaded, mon_e.loaded);
            chk("done_load_err",   bus.load_err,   mon_e.err);
            chk("done_key_ready",  bus.key_ready,  0);
            chk("done_cycle",      cyc,            mon_e.cyc);
            exp_key    = mon_e.key;
            exp_loaded = mon_e.loaded;
          end
        end else begin
          chk("hold_key_out",    bus.key_out,    exp_key);
          chk("hold_key_loaded", bus.key_loaded, exp_loaded);
        end
        prev_busy = bus.busy;
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    idle_inputs();
    rst_n = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1;
    tick();

    // First key, commit two edges after the last bit.
    load_key(16'hA5C3, 1'b0, 1'b0, mk(16'hA5C3, 1'b1, 1'b0));
`ifdef KEY_PARITY_CHECK_EN
    // Odd total parity: rejected, previous key retained.
    load_key(16'h0001, 1'b0, 1'b0, mk(16'hA5C3, 1'b1, 1'b1));
`endif
    // key_valid toggling every cycle.
    load_key(16'hFFFF, 1'b0, 1'b1, mk(16'hFFFF, 1'b1, 1'b0));

    // Restart after eight bits, then a clean load.
    start();
    shift_bits(16'hFFFF, 1'b0, 8, 1'b0, 1'b0, mk(16'h0, 1'b0, 1'b0));
    load_key(16'h1234, 1'b1, 1'b0, mk(16'h1234, 1'b1, 1'b0));

    // Abort from a locked key keeps it.
    abort_after_11(mk(16'h1234, 1'b1, 1'b0));

    // Abort from idle after reset leaves nothing loaded.
    rst_n = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
    abort_after_11(mk(16'h0000, 1'b0, 1'b0));

    // Reset during CHECK discards the pending key.
    load_key(16'h1234, 1'b1, 1'b0, mk(16'h1234, 1'b1, 1'b0));
    start();
    shift_bits(16'hA5C3, 1'b0, N, 1'b0, 1'b0, mk(16'h0, 1'b0, 1'b0));
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    repeat (4) tick();

    // Recovery load after the interrupted one.
    load_key(16'h5A3C, 1'b0, 1'b0, mk(16'h5A3C, 1'b1, 1'b0));

    for (int i = 0; i < 50 && sb.size() != 0; i++) tick();
    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain got=%0d want=0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/key_loader.md
KEY_LOADER -- requirements
Module: key_loader

Interface
REQ-001 Parameter KEY_W, default 16, SHALL set the number of key bits delivered to the locked netlist's keyIn_0_0..keyIn_0_(KEY_W-1) ports.
REQ-002 clk  input  1  SHALL be the single clock; all state SHALL update on its rising edge.
REQ-003 rst_n  input  1  SHALL be the reset, asynchronous and active-low.
REQ-004 load_start  input  1  SHALL be a one-cycle pulse that begins a key load.
REQ-005 key_bit  input  1  SHALL carry serial key data, LSB first.
REQ-006 key_valid  input  1  SHALL qualify key_bit.
REQ-007 key_ready  output  1  SHALL be high only in SHIFT.
REQ-008 load_abort  input  1  SHALL cancel an in-progress load.
REQ-009 key_out  output  KEY_W  SHALL drive the committed key; key_out[i] SHALL connect to keyIn_0_i.
REQ-010 key_loaded  output  1  SHALL be high while a committed key is present.
REQ-011 load_err  output  1  SHALL flag a failed load.
REQ-012 busy  output  1  SHALL be high in SHIFT or CHECK.

Function
REQ-013 The FSM SHALL have exactly these states: IDLE, SHIFT, CHECK, LOCKED and ERROR.
REQ-014 IDLE, LOCKED or ERROR with load_start=1 SHALL go to SHIFT on the next edge, clearing the shadow register, the bit counter and load_err.
REQ-015 In SHIFT, each edge where key_valid && key_ready SHALL write key_bit into shadow[count] and increment count; with key_valid=0, state SHALL hold.
REQ-016 The edge that accepts the final bit (count = N-1, N = KEY_W, or KEY_W+1 with parity) SHALL move the FSM to CHECK.
REQ-017 CHECK SHALL last one cycle; on pass, the next edge SHALL load shadow into key_out, set key_loaded=1 and enter LOCKED.
REQ-018 Latency SHALL be exactly 2 edges from the last accepted bit to key_out update.
REQ-019 On check failure, the FSM SHALL enter ERROR with load_err=1, key_out unchanged and key_loaded unchanged.
REQ-020 key_out SHALL never change except on a successful commit or reset; no partial key SHALL ever be visible.
REQ-021 load_start in SHIFT SHALL restart the load: count=0 and shadow cleared on the next edge; load_start SHALL take priority over a simultaneous key_valid.
REQ-022 load_abort in SHIFT SHALL return the FSM to LOCKED if key_loaded=1, else to IDLE; the shadow SHALL be discarded. load_abort SHALL take priority over load_start and key_valid.
REQ-023 load_abort and load_start in CHECK SHALL be ignored.
REQ-024 The counter SHALL be ceil(log2(KEY_W+2)) bits wide and SHALL never wrap; bits beyond N SHALL not be accepted because key_ready is low outside SHIFT.

Reset
REQ-025 rst_n=0 SHALL immediately force: state=IDLE, key_out=0, key_loaded=0, load_err=0, busy=0, key_ready=0, count=0, shadow=0.
REQ-026 Reset asserted mid-load or mid-CHECK SHALL discard the load, with no commit.
REQ-027 Reset deassertion SHALL be synchronised externally; the block SHALL leave IDLE only on load_start.

Configuration
REQ-028 With KEY_PARITY_CHECK_EN defined, N = KEY_W+1: the final serial bit SHALL be even parity over all KEY_W bits, and CHECK SHALL pass only if the XOR of all N bits is 0.
REQ-029 Without KEY_PARITY_CHECK_EN, N = KEY_W, CHECK SHALL always pass, and load_err SHALL be tied 0.

Verification
REQ-030 Reset, then load_start and 16 bits of 0xA5C3 LSB-first (plus parity 0 if enabled) with key_valid held high -> key_out=0xA5C3 and key_loaded=1 two edges after the last bit; busy=0.
REQ-031 Parity enabled; load 0x0001 with parity bit 0 -> ERROR, load_err=1, key_out keeps its prior value 0xA5C3.
REQ-032 Key_valid toggled 1/0 every cycle during a load of 0xFFFF -> correct commit after 32 cycles of SHIFT, and key_out stays 0xA5C3 until the commit edge.
REQ-033 load_start after bit 7 of a load, then a full load of 0x1234 -> key_out=0x1234, with no leakage of the earlier bits.
REQ-034 load_abort after bit 10 while LOCKED with 0x1234 -> state LOCKED, key_out=0x1234; the same from IDLE after reset -> IDLE, key_out=0.
REQ-035 rst_n pulsed low for 1 cycle mid-CHECK -> all outputs 0 asynchronously and no commit afterwards.
